// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Multi-cycle sequencer that performs a NIBBLES x 4-bit add, subtract, AND
//   or OR on an external combinational 4-bit ALU slice. It processes one
//   nibble per cycle, least-significant nibble first, and carries the carry
//   between nibbles in a register.
//
//   Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add a registered
//   out_zero flag that reports whether the final result is zero.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       operand handshake (accepted only in IDLE)
//   in_a, in_b              W-bit operands, W = 4*NIBBLES
//   in_op                   00 add, 01 sub (A-B), 10 AND, 11 OR
//   in_cin                  carry-in, used by add only
//   out_valid/out_ready     result handshake (valid only in DONE)
//   out_result, out_cout    result and final carry (sub: 1 = no borrow)
//   out_zero                out_result == 0 (ALU_SEQ_ZERO_FLAG_EN only)
//   alu_a, alu_b, alu_op,   inputs driven to the external slice, zero
//   alu_cin                 outside RUN
//   alu_result, alu_cout    combinational slice outputs
module alu_seq_ctrl #(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_op,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic         out_zero,
`endif
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [1:0]   alu_op,
    output logic         alu_cin,
    input  logic [3:0]   alu_result,
    input  logic         alu_cout
);

    localparam int unsigned IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic [1:0]      op_q,     op_d;
    logic            carry_q,  carry_d;
    logic [W-1:0]    result_q, result_d;

    // Bit offset of the current nibble inside the operand/result words.
    logic [IDXW+1:0] nib_base;
    logic            op_is_arith;
    logic            op_is_sub;

    assign nib_base    = {idx_q, 2'b00};
    assign op_is_arith = ~op_q[1];
    assign op_is_sub   = (op_q == OP_SUB);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        alu_cin   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    op_d     = in_op;
                    idx_d    = '0;
                    // Sub seeds carry=1 so A + ~B + 1 forms the two's-complement difference.
                    carry_d  = (in_op == OP_ADD) ? in_cin : (in_op == OP_SUB);
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                alu_a   = a_q[nib_base +: 4];
                alu_b   = op_is_sub ? ~b_q[nib_base +: 4] : b_q[nib_base +: 4];
                // Subtraction is issued to the slice as an add with inverted B.
                alu_op  = op_is_sub ? OP_ADD : op_q;
                alu_cin = op_is_arith & carry_q;

                result_d[nib_base +: 4] = alu_result;
                carry_d = op_is_arith & alu_cout;

                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    assign out_result = result_q;
    assign out_cout   = carry_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_q, zero_d;

    // Captured on the DONE entry edge from the fully assembled result.
    always_comb begin
        zero_d = zero_q;
        if (state_q == ST_RUN && idx_q == LAST_IDX) begin
            zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl with NIBBLES=4. Models the external ALU slice,
// keeps a queue of expected results filled at accept time and drained when
// the DUT completes an output handshake.
module tb_alu_seq_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         out_zero;
`endif
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [1:0]   alu_op;
    logic         alu_cin;
    logic [3:0]   alu_result;
    logic         alu_cout;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_seq_ctrl #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .out_zero   (out_zero),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit slice. Opcode 01 deliberately computes A-B without carry
    // so any illegal use of it corrupts the result.
    always_comb begin
        logic [4:0] s;
        s = '0;
        unique case (alu_op)
            2'b00:   s = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
            2'b01:   s = {1'b0, alu_a - alu_b};
            2'b10:   s = {1'b0, alu_a & alu_b};
            default: s = {1'b0, alu_a | alu_b};
        endcase
        alu_result = s[3:0];
        alu_cout   = s[4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic cin);
        logic [W:0] s;
        exp_t e;
        unique case (op)
            2'b00:   s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            2'b01:   s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            2'b10:   s = {1'b0, a & b};
            default: s = {1'b0, a | b};
        endcase
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.zero = (s[W-1:0] == '0);
        return e;
    endfunction

    task automatic check_alu_idle(input string tag);
        check({tag, "_alu_a"},   alu_a,   0);
        check({tag, "_alu_b"},   alu_b,   0);
        check({tag, "_alu_op"},  alu_op,  0);
        check({tag, "_alu_cin"}, alu_cin, 0);
    endtask

    // Output side of the scoreboard: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", out_result, e.res);
                check("sb_cout",   out_cout,   e.cout);
`ifdef ALU_SEQ_ZERO_FLAG_EN
                check("sb_zero",   out_zero,   e.zero);
`endif
            end
        end
    end

    // Issue one operation, check RUN-phase slice drive and DONE timing.
    // Returns at accept edge + N + #1 (DONE) when out_ready is low, or one
    // cycle later (back in IDLE) when out_ready is high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin);
        int unsigned guard;
        logic [W-1:0] bx;
        logic [1:0]   exp_op;
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_cin = cin;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        sb.push_back(model(a, b, op, cin));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bx     = (op == 2'b01) ? ~b : b;
        exp_op = (op == 2'b01) ? 2'b00 : op;
        for (int unsigned k = 0; k < N; k++) begin
            check("run_out_valid", out_valid, 0);
            check("run_in_ready",  in_ready,  0);
            check("run_alu_a",  alu_a,  (a  >> (4 * k)) & 16'hF);
            check("run_alu_b",  alu_b,  (bx >> (4 * k)) & 16'hF);
            check("run_alu_op", alu_op, exp_op);
            if (op[1]) begin
                check("run_alu_cin_logic", alu_cin, 0);
            end else if (k == 0) begin
                check("run_alu_cin_first", alu_cin, (op == 2'b01) ? 1 : cin);
            end
            @(posedge clk);
            #1;
        end
        check("done_out_valid", out_valid, 1);
        check("done_in_ready",  in_ready,  0);
        check_alu_idle("done");
        if (out_ready) begin
            @(posedge clk);
            #1;
            check("post_out_valid", out_valid, 0);
            check("post_in_ready",  in_ready,  1);
            check_alu_idle("idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t bp;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   in_ready,   1);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_result", out_result, 0);
        check("rst_out_cout",   out_cout,   0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("rst_out_zero",   out_zero,   0);
`endif
        check_alu_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        run_op(16'h1234, 16'h0FFF, 2'b00, 1'b0);
        run_op(16'hFFFF, 16'h0001, 2'b00, 1'b0);
        run_op(16'h0000, 16'h0000, 2'b00, 1'b1);
        run_op(16'h0007, 16'h0005, 2'b01, 1'b0);
        run_op(16'h0005, 16'h0007, 2'b01, 1'b1);
        run_op(16'hF0F0, 16'h3C3C, 2'b10, 1'b1);
        run_op(16'hF0F0, 16'h3C3C, 2'b11, 1'b0);

        // Backpressure in DONE with a stray in_valid pulse.
        out_ready = 1'b0;
        bp = model(16'h0005, 16'h0007, 2'b01, 1'b0);
        run_op(16'h0005, 16'h0007, 2'b01, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            check("bp_out_valid",  out_valid,  1);
            check("bp_out_result", out_result, bp.res);
            check("bp_out_cout",   out_cout,   bp.cout);
            check("bp_in_ready",   in_ready,   0);
            if (i == 2) begin
                in_a = 16'h1111; in_b = 16'h2222; in_op = 2'b00;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_release_valid", out_valid, 1);
        @(posedge clk);
        #1;
        check("bp_post_valid", out_valid, 0);
        check("bp_post_ready", in_ready,  1);
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_accept", out_valid, 0);

        // Reset during nibble 2 of an add discards the operation.
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1111; in_op = 2'b00; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",   in_ready,   1);
        check("abort_out_valid",  out_valid,  0);
        check("abort_out_result", out_result, 0);
        check("abort_out_cout",   out_cout,   0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("abort_out_zero",   out_zero,   0);
`endif
        check_alu_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", out_valid, 0);
        end

        run_op(16'h1234, 16'h0FFF, 2'b00, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that performs NIBBLES×4-bit add, subtract, AND and OR operations on an external combinational 4-bit ALU slice. It processes one nibble per cycle, least-significant first, and chains the carry between nibbles in a register. It sits between a valid/ready operand source and a valid/ready result sink. It owns the ALU slice's inputs exclusively.

## Interface

Parameters:
- NIBBLES, default 4: number of 4-bit slices per operation; W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand request valid
- in_ready  out  1  controller can accept an operation
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_op  in  2  operation: 00 add, 01 sub (A−B), 10 AND, 11 OR
- in_cin  in  1  carry-in, used for add only
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_result  out  W  result
- out_cout  out  1  final carry; for sub it is 1 when no borrow occurred; 0 for AND/OR
- out_zero  out  1  out_result == 0 (present only with ALU_SEQ_ZERO_FLAG_EN)
- alu_a  out  4  current nibble of A
- alu_b  out  4  current nibble of B; inverted for sub
- alu_op  out  2  opcode driven to the slice
- alu_cin  out  1  carry into the slice
- alu_result  in  4  slice result, combinational
- alu_cout  in  1  slice carry-out, combinational

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a, in_b and in_op.
  - Set idx=0.
  - Set carry register: add → in_cin; sub → 1; AND/OR → 0.
  - Clear the result register. Go to RUN.
- RUN (in_ready=0): drive the slice combinationally from the nibble at idx:
  - alu_a = A[4*idx+3:4*idx].
  - alu_b = sub ? ~B nibble : B nibble.
  - alu_op = (op==01) ? 00 : op. Subtraction is always issued to the slice as add-with-inverted-B. Opcode 01 is never driven to the slice.
  - alu_cin = carry register for add/sub; 0 for AND/OR.
  - Each cycle, register alu_result into result nibble idx.
  - Carry register ← alu_cout for add/sub; 0 for AND/OR.
  - idx increments each cycle. When idx==NIBBLES−1, go to DONE after that cycle's capture.
- DONE:
  - out_valid=1; out_result and out_cout hold the registered values.
  - Both are stable until out_valid&&out_ready, then go to IDLE.
  - in_ready=0.
- In IDLE and DONE, alu_a, alu_b, alu_op and alu_cin are all 0.
- in_valid while in_ready=0 is ignored; the source must hold its request.
- Arithmetic is modulo 2^W. Overflow is reported only via out_cout; there is no signed overflow flag.

## Timing

- Reset values (asynchronous, on rst_n low):
  - State=IDLE, idx=0, carry=0, result=0.
  - out_valid=0, out_result=0, out_cout=0, out_zero=0.
  - alu_* outputs = 0.
  - in_ready=1 once state is IDLE.
- Latency: on the accept edge (T0), the state becomes RUN. Nibble k is captured at edge T0+1+k. out_valid rises after edge T0+NIBBLES.
- Minimum occupancy is NIBBLES+2 cycles per operation: NIBBLES in RUN, ≥1 in DONE, 1 in IDLE. There is no pipelining and no accept in DONE.
- out_ready held high in DONE: the result is consumed in exactly one cycle.
- rst_n asserted mid-RUN or mid-DONE: the operation is discarded and no out_valid pulse is produced. The next accepted operation is unaffected.
- rst_n release is synchronised externally. The block's first accept is possible on the first rising edge with rst_n high.

## Configuration

- ALU_SEQ_ZERO_FLAG_EN defined:
  - out_zero port exists.
  - It is registered and updated on the DONE entry edge to (final result == 0).
  - It is valid under the same conditions as out_valid and reset to 0.
- Not defined: no out_zero port and no zero-detect logic. All other behaviour is identical.

## Test plan

NIBBLES=4.

- Add 0x1234 + 0x0FFF, cin=0, out_ready=1 → out_result=0x2233, out_cout=0. out_valid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
- Add 0xFFFF + 0x0001, cin=0 → 0x0000, out_cout=1, out_zero=1 (with EN). Add 0x0000 + 0x0000, cin=1 → 0x0001, out_zero=0.
- Sub 0x0007 − 0x0005 → 0x0002, out_cout=1. Sub 0x0005 − 0x0007 → 0xFFFE, out_cout=0. alu_op reads 00 and alu_cin reads 1 in the first RUN cycle.
- AND 0xF0F0 & 0x3C3C → 0x3030. OR of the same operands → 0xFCFC. Both give out_cout=0; alu_op reads 10/11 and alu_cin reads 0 throughout.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid pulsed → out_valid, out_result and out_cout stay stable, in_ready=0, and the pulse is not accepted. Releasing out_ready gives a 1-cycle handshake, then in_ready=1.
- Reset with rst_n low during nibble 2 of an add → all outputs go to reset values immediately and no out_valid appears. A subsequent 0x1234 + 0x0FFF yields 0x2233.
